// File: rtl/bless_inject_ni_pkg.sv
// Shared widths, control-word layout and queue entry format for the BLESS injection interface.
package bless_inject_ni_pkg;

  localparam int unsigned AddrN = 4;
  localparam int unsigned SeqN  = 4;
  localparam int unsigned AgeN  = 3;
  localparam int unsigned DataW = 16;

  // Control word, MSB first: {valid, seq, src, dest, age}
  localparam int unsigned AgeLsb   = 0;
  localparam int unsigned DestLsb  = AgeLsb + AgeN;
  localparam int unsigned SrcLsb   = DestLsb + AddrN;
  localparam int unsigned SeqLsb   = SrcLsb + AddrN;
  localparam int unsigned ValidBit = SeqLsb + SeqN;
  localparam int unsigned ControlW = ValidBit + 1;

  typedef struct packed {
    logic             valid;
    logic [SeqN-1:0]  seq;
    logic [AddrN-1:0] src;
    logic [AddrN-1:0] dest;
    logic [AgeN-1:0]  age;
  } ni_ctrl_t;

  typedef struct packed {
    logic [AddrN-1:0] dest;
    logic [SeqN-1:0]  seq;
    logic [DataW-1:0] data;
  } ni_entry_t;

  localparam int unsigned EntryW = $bits(ni_entry_t);

  typedef enum logic {
    StEmpty,
    StHold
  } stage_e;

  function automatic logic [AgeN-1:0] age_sat_inc(input logic [AgeN-1:0] age);
    return (&age) ? age : age + AgeN'(1);
  endfunction

endpackage

// File: rtl/bless_flit_fifo.sv
// Circular flit queue with synchronous active-low flush; no push bypass when full.
module bless_flit_fifo #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 24
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [Width-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [Width-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(Depth):0]     count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Depth is a power of two, so pointers wrap naturally.
  always_comb begin
    wptr_d  = wptr_q + PtrW'(do_push);
    rptr_d  = rptr_q + PtrW'(do_pop);
    count_d = count_q + CntW'(do_push) - CntW'(do_pop);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/bless_inject_ni.sv
// Node injection interface: queues core flits, stamps seq/src/age and offers them to the router.
module bless_inject_ni
  import bless_inject_ni_pkg::*;
#(
  parameter int unsigned NODE_ADDR = 0,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [AddrN-1:0]          in_dest,
  input  logic                      in_last,
  input  logic [DataW-1:0]          in_data,
  input  logic                      inj_ok,
  output logic [ControlW-1:0]       ci,
  output logic [DataW-1:0]          di,
  output logic [$clog2(DEPTH):0]    occupancy,
  output logic [CNT_W-1:0]          inj_cnt
);

  logic      fifo_full, fifo_empty;
  logic      push, pop, accept;
  ni_entry_t push_entry, head;
  ni_ctrl_t  ctrl;

  stage_e           st_q, st_d;
  ni_entry_t        stage_q, stage_d;
  logic [AgeN-1:0]  age_q, age_d;
  logic [SeqN-1:0]  seq_q, seq_d;
  logic [CNT_W-1:0] inj_cnt_q, inj_cnt_d;

  assign in_ready = rst && !fifo_full;
  assign push     = in_valid && in_ready;
  assign accept   = (st_q == StHold) && inj_ok;
  // Reload on the accept edge keeps injection back-to-back.
  assign pop      = !fifo_empty && ((st_q == StEmpty) || accept);

  assign push_entry = '{dest: in_dest, seq: seq_q, data: in_data};

  bless_flit_fifo #(
    .Depth (DEPTH),
    .Width (EntryW)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (push),
    .wdata_i (push_entry),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (occupancy)
  );

  always_comb begin
    st_d      = st_q;
    stage_d   = stage_q;
    age_d     = age_q;
    seq_d     = seq_q;
    inj_cnt_d = inj_cnt_q;

    if (push) begin
      seq_d = in_last ? '0 : seq_q + SeqN'(1);
    end

    if (accept) begin
      inj_cnt_d = inj_cnt_q + CNT_W'(1);
    end

    if (pop) begin
      st_d    = StHold;
      stage_d = head;
      age_d   = '0;
    end else if (accept) begin
      st_d    = StEmpty;
      stage_d = '0;
      age_d   = '0;
    end else if (st_q == StHold) begin
      age_d = age_sat_inc(age_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      st_q      <= StEmpty;
      stage_q   <= '0;
      age_q     <= '0;
      seq_q     <= '0;
      inj_cnt_q <= '0;
    end else begin
      st_q      <= st_d;
      stage_q   <= stage_d;
      age_q     <= age_d;
      seq_q     <= seq_d;
      inj_cnt_q <= inj_cnt_d;
    end
  end

  always_comb begin
    ctrl = '0;
    if (st_q == StHold) begin
      ctrl = '{valid: 1'b1, seq: stage_q.seq, src: AddrN'(NODE_ADDR), dest: stage_q.dest,
               age: age_q};
    end
  end

  assign ci      = ctrl;
  assign di      = stage_q.data;
  assign inj_cnt = inj_cnt_q;

endmodule
